router_pkt_ctrl: RTL

//  Ingress controller for the 1x3 router. Sits between the source interface (pkt_valid/data_in/busy/error)
//  and the three output FIFOs. Decodes the header byte, sequences FIFO writes, back-pressures the source

---
 rtl/router_pkt_ctrl_if.sv | 26 ++
 rtl/router_pkt_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_ctrl_if.sv
// Source/FIFO-side signal bundle for the 1x3 router ingress controller.
// The controller connects through the slave modport; the source/FIFO side uses master.
interface router_pkt_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic       error;
  logic [2:0] write_enb;
  logic [7:0] din_fifo;
  logic       lfd_state;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  busy, error, write_enb, din_fifo, lfd_state, vld_out, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output busy, error, write_enb, din_fifo, lfd_state, vld_out, soft_reset
  );
endinterface

// File: rtl/router_pkt_ctrl.sv
// Ingress controller for the 1x3 router: header decode, FIFO write sequencing, parity check.
// Optional per-port FIFO flush timers are built when ROUTER_SOFT_RST_EN is defined.
module router_pkt_ctrl #(
  parameter int unsigned TIMEOUT          = 30,
  parameter int unsigned TMR_W            = 5,
  parameter bit          INVALID_ADDR_ERR = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  router_pkt_ctrl_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 3;
  localparam int unsigned LW = 6;

  // One-hot states so busy decodes straight from register bits.
  typedef enum logic [7:0] {
    IDLE       = 8'b0000_0001,
    WAIT_EMPTY = 8'b0000_0010,
    WR_HDR     = 8'b0000_0100,
    LOAD_DATA  = 8'b0000_1000,
    LOAD_PAR   = 8'b0001_0000,
    FULL_HOLD  = 8'b0010_0000,
    CHECK_PAR  = 8'b0100_0000,
    DROP       = 8'b1000_0000
  } state_t;

  localparam logic [7:0] BUSY_MASK = 8'b0110_0110;

  if (TIMEOUT == 0 || TIMEOUT > (2 ** TMR_W) - 1) begin : g_tmr_chk
    $error("TMR_W too narrow for TIMEOUT");
  end

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [DW-1:0]   hdr_q, hdr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   par_q, par_d;
  logic [DW-1:0]   rx_par_q, rx_par_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            ret_par_q, ret_par_d;
  logic            error_q, error_d;

  logic            busy;
  logic            accept;
  logic            full_a;
  logic            empty_a;
  logic            wr;
  logic            lfd;
  logic [DW-1:0]   din;

  assign busy    = |(state_q & BUSY_MASK);
  assign accept  = bus.pkt_valid & ~busy;
  assign full_a  = bus.fifo_full[addr_q];
  assign empty_a = bus.fifo_empty[addr_q];

  // Next-state and write-path decode; payload writes pass data_in through with no added latency.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    par_d     = par_q;
    rx_par_d  = rx_par_q;
    hold_d    = hold_q;
    ret_par_d = ret_par_q;
    error_d   = error_q;
    wr        = 1'b0;
    lfd       = 1'b0;
    din       = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hdr_d   = bus.data_in;
          addr_d  = bus.data_in[1:0];
          rem_d   = bus.data_in[7:2];
          par_d   = bus.data_in;
          error_d = 1'b0;
          if (bus.data_in[1:0] == 2'd3)                state_d = DROP;
          else if (bus.fifo_empty[bus.data_in[1:0]])   state_d = WR_HDR;
          else                                         state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        if (empty_a) state_d = WR_HDR;
      end
      WR_HDR: begin
        wr      = 1'b1;
        lfd     = 1'b1;
        din     = hdr_q;
        state_d = (rem_q != '0) ? LOAD_DATA : LOAD_PAR;
      end
      LOAD_DATA: begin
        if (accept) begin
          par_d = par_q ^ bus.data_in;
          rem_d = LW'(rem_q - LW'(1));
          if (!full_a) begin
            wr  = 1'b1;
            din = bus.data_in;
            if (rem_q == LW'(1)) state_d = LOAD_PAR;
          end else begin
            hold_d    = bus.data_in;
            ret_par_d = 1'b0;
            state_d   = FULL_HOLD;
          end
        end
      end
      LOAD_PAR: begin
        if (accept) begin
          rx_par_d = bus.data_in;
          if (!full_a) begin
            wr      = 1'b1;
            din     = bus.data_in;
            state_d = CHECK_PAR;
          end else begin
            hold_d    = bus.data_in;
            ret_par_d = 1'b1;
            state_d   = FULL_HOLD;
          end
        end
      end
      FULL_HOLD: begin
        din = hold_q;
        if (!full_a) begin
          wr = 1'b1;
          if (ret_par_q)           state_d = CHECK_PAR;
          else if (rem_q != '0)    state_d = LOAD_DATA;
          else                     state_d = LOAD_PAR;
        end
      end
      CHECK_PAR: begin
        error_d = (rx_par_q != par_q);
        state_d = IDLE;
      end
      DROP: begin
        if (accept) begin
          if (rem_q == '0) begin
            error_d = INVALID_ADDR_ERR;
            state_d = IDLE;
          end else begin
            rem_d = LW'(rem_q - LW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hdr_q     <= '0;
      rem_q     <= '0;
      par_q     <= '0;
      rx_par_q  <= '0;
      hold_q    <= '0;
      ret_par_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hdr_q     <= hdr_d;
      rem_q     <= rem_d;
      par_q     <= par_d;
      rx_par_q  <= rx_par_d;
      hold_q    <= hold_d;
      ret_par_q <= ret_par_d;
      error_q   <= error_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.error     = error_q;
  assign bus.lfd_state = lfd;
  assign bus.din_fifo  = din;
  assign bus.write_enb = wr ? NP'(3'b001 << addr_q) : 3'b000;
  assign bus.vld_out   = ~bus.fifo_empty;

`ifdef ROUTER_SOFT_RST_EN
  logic [TMR_W-1:0] tmr_q [NP];
  logic [NP-1:0]    sr_q;

  // Flush a port whose data has sat unread for TIMEOUT consecutive cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NP; i++) tmr_q[i] <= '0;
      sr_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (bus.vld_out[i] && !bus.read_enb[i]) begin
          if (tmr_q[i] == TMR_W'(TIMEOUT - 1)) begin
            tmr_q[i] <= '0;
            sr_q[i]  <= 1'b1;
          end else begin
            tmr_q[i] <= TMR_W'(tmr_q[i] + TMR_W'(1));
            sr_q[i]  <= 1'b0;
          end
        end else begin
          tmr_q[i] <= '0;
          sr_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.soft_reset = sr_q;
`else
  logic unused_read_enb;
  assign unused_read_enb = ^bus.read_enb;
  assign bus.soft_reset  = 3'b000;
`endif

endmodule
